// File: rtl/add_sub_pkg.sv
// Shared constants, FIFO entry layout and helpers for the add_sub streaming stage.
package add_sub_pkg;

  localparam int W          = 4;
  localparam int TAG_W      = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;
  localparam int FIFO_CNT_W = 2;

  // One FIFO entry: everything the consumer sees for a single command.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     sum;
    logic             ovf;
    logic             sub;
  } add_sub_res_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational 4-bit adder/subtractor with carry-out / borrow flag.
module add_sub (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       SUBTRACT,
  output logic [3:0] SUM,
  output logic       OVERFLOW
);

  logic [4:0] res_s;

  // 5-bit add or subtract; bit 4 is the carry (add) or the borrow A<B (sub).
  always_comb begin
    if (SUBTRACT) begin
      res_s = {1'b0, A} - {1'b0, B};
    end else begin
      res_s = {1'b0, A} + {1'b0, B};
    end
  end

  assign SUM      = res_s[3:0];
  assign OVERFLOW = res_s[4];

endmodule

// File: rtl/add_sub_sva.sv
// Checker for the add_sub datapath, bound into the streaming stage so it
// observes the add_sub instance's ports on the stage clock.
module add_sub_sva (
  input logic       clk,
  input logic       rst,
  input logic       en_i,
  input logic [3:0] a_i,
  input logic [3:0] b_i,
  input logic       sub_i,
  input logic [3:0] sum_i,
  input logic       ovf_i
);

  logic [4:0] exp_s;

  // Independent reference for {OVERFLOW, SUM}.
  always_comb begin
    if (sub_i) begin
      exp_s = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      exp_s = {1'b0, a_i} + {1'b0, b_i};
    end
  end

  a_add_sub_result: assert property (@(posedge clk) disable iff (rst || !en_i)
    {ovf_i, sum_i} == exp_s)
    else $error("add_sub result wrong: a=%0h b=%0h sub=%0b got %0h want %0h",
                a_i, b_i, sub_i, {ovf_i, sum_i}, exp_s);

endmodule

bind add_sub_stream add_sub_sva u_add_sub_sva (
  .clk   (clk),
  .rst   (rst),
  .en_i  (in_valid),
  .a_i   (in_a),
  .b_i   (in_b),
  .sub_i (in_sub),
  .sum_i (as_sum_s),
  .ovf_i (as_ovf_s)
);

// File: rtl/add_sub_stream.sv
// Valid/ready wrapper around add_sub: 2-entry result FIFO plus a saturating
// overflow/borrow event counter. Head entry is held in a register so the
// out_* fields come straight from flops.
module add_sub_stream
  import add_sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic             out_sub,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam logic [FIFO_CNT_W-1:0] FULL_C = FIFO_CNT_W'(FIFO_DEPTH);

  logic [W-1:0]            as_sum_s;
  logic                    as_ovf_s;
  logic                    accept_s;
  logic                    deliver_s;
  add_sub_res_t            new_s;
  add_sub_res_t            head_q, head_d;
  add_sub_res_t            tail_q, tail_d;
  logic [FIFO_CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]        ovf_cnt_q, ovf_cnt_d;

  add_sub u_add_sub (
    .A        (in_a),
    .B        (in_b),
    .SUBTRACT (in_sub),
    .SUM      (as_sum_s),
    .OVERFLOW (as_ovf_s)
  );

  // in_ready looks only at registered occupancy (and reset), never at out_ready.
  assign in_ready  = (count_q < FULL_C) && !rst;
  assign out_valid = (count_q != {FIFO_CNT_W{1'b0}});
  assign accept_s  = in_valid && in_ready;
  assign deliver_s = out_valid && out_ready;

  assign new_s.tag = in_tag;
  assign new_s.sum = as_sum_s;
  assign new_s.ovf = as_ovf_s;
  assign new_s.sub = in_sub;

  // FIFO next state: head is slot 0, tail is slot 1; a pop shifts tail to head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({accept_s, deliver_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_d = new_s;
        end else begin
          tail_d = new_s;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        head_d  = tail_q;
      end
      2'b11: begin
        // Push and pop together: occupancy unchanged, head advances.
        if (count_q == 2'd1) begin
          head_d = new_s;
        end else begin
          head_d = tail_q;
          tail_d = new_s;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Event counter next state: clear wins over a same-cycle increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && as_ovf_s) begin
      ovf_cnt_d = sat_inc(ovf_cnt_q);
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // State registers; reset empties the FIFO and zeroes the visible head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= {FIFO_CNT_W{1'b0}};
      ovf_cnt_q <= {CNT_W{1'b0}};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign out_sum = head_q.sum;
  assign out_ovf = head_q.ovf;
  assign out_sub = head_q.sub;
  assign out_tag = head_q.tag;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_add_sub_stream.sv
// Directed bench for add_sub_stream with hand-computed expected values.
module tb_add_sub_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_sub;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_ovf;
  logic       out_sub;
  logic [3:0] out_tag;
  logic [7:0] ovf_cnt;
  logic       cnt_clr;

  int n_tests;
  int n_fail;

  add_sub_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_sub   (out_sub),
    .out_tag   (out_tag),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [3:0] t);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    in_tag   = t;
  endtask

  task automatic expect_head(input string tg, input logic [3:0] sum, input logic ovf,
                             input logic s, input logic [3:0] t);
    check({tg, ".valid"}, 32'(out_valid), 32'd1);
    check({tg, ".sum"},   32'(out_sum),   32'(sum));
    check({tg, ".ovf"},   32'(out_ovf),   32'(ovf));
    check({tg, ".sub"},   32'(out_sub),   32'(s));
    check({tg, ".tag"},   32'(out_tag),   32'(t));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_sub    = 1'b0;
    in_tag    = 4'd0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_sum",   32'(out_sum),   32'd0);
    check("rst.out_tag",   32'(out_tag),   32'd0);
    check("rst.ovf_cnt",   32'(ovf_cnt),   32'd0);
    rst = 1'b0;
    #1;
    check("rel.in_ready",  32'(in_ready),  32'd1);

    // Arithmetic, back-to-back with out_ready=1
    out_ready = 1'b1;
    drive(4'h3, 4'h4, 1'b0, 4'd1); step(); expect_head("add", 4'h7, 1'b0, 1'b0, 4'd1);
    check("add.cnt", 32'(ovf_cnt), 32'd0);
    drive(4'hF, 4'h1, 1'b0, 4'd2); step(); expect_head("carry", 4'h0, 1'b1, 1'b0, 4'd2);
    check("carry.cnt", 32'(ovf_cnt), 32'd1);
    drive(4'h0, 4'h1, 1'b1, 4'd3); step(); expect_head("borrow", 4'hF, 1'b1, 1'b1, 4'd3);
    check("borrow.cnt", 32'(ovf_cnt), 32'd2);
    drive(4'hF, 4'hF, 1'b1, 4'd4); step(); expect_head("subeq", 4'h0, 1'b0, 1'b1, 4'd4);
    drive(4'h9, 4'h8, 1'b1, 4'd5); step(); expect_head("sub", 4'h1, 1'b0, 1'b1, 4'd5);
    drive(4'hA, 4'h7, 1'b0, 4'd6); step(); expect_head("add17", 4'h1, 1'b1, 1'b0, 4'd6);
    check("add17.cnt", 32'(ovf_cnt), 32'd3);
    in_valid = 1'b0;
    step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(4'h1, 4'h1, 1'b0, 4'd1); step();
    check("bp1.in_ready", 32'(in_ready), 32'd1);
    drive(4'h2, 4'h2, 1'b0, 4'd2); step();
    check("bp2.in_ready", 32'(in_ready), 32'd0);
    expect_head("bp2.head", 4'h2, 1'b0, 1'b0, 4'd1);
    drive(4'h3, 4'h3, 1'b0, 4'd3); step();
    check("bp3.in_ready", 32'(in_ready), 32'd0);
    expect_head("bp3.head", 4'h2, 1'b0, 1'b0, 4'd1);
    out_ready = 1'b1;
    step();
    expect_head("bp.pop1", 4'h4, 1'b0, 1'b0, 4'd2);
    check("bp.pop1.in_ready", 32'(in_ready), 32'd1);
    step();
    expect_head("bp.pop2", 4'h6, 1'b0, 1'b0, 4'd3);
    in_valid = 1'b0;
    step();
    check("bp.empty", 32'(out_valid), 32'd0);
    check("bp.cnt",   32'(ovf_cnt),   32'd3);

    // Counter saturation: 3 + 260 overflowing adds, clipped at 255
    drive(4'hF, 4'hF, 1'b0, 4'd7);
    for (int i = 0; i < 260; i++) begin
      step();
      if (i == 250) check("sat.254", 32'(ovf_cnt), 32'd254);
      if (i == 251) check("sat.255", 32'(ovf_cnt), 32'd255);
    end
    check("sat.hold", 32'(ovf_cnt), 32'd255);
    expect_head("sat.head", 4'hE, 1'b1, 1'b0, 4'd7);
    cnt_clr = 1'b1;
    step();
    check("clr.prio", 32'(ovf_cnt), 32'd0);
    cnt_clr = 1'b0;
    step();
    check("clr.after", 32'(ovf_cnt), 32'd1);
    in_valid = 1'b0;
    step();
    check("sat.empty", 32'(out_valid), 32'd0);

    // Reset mid-stream with a full FIFO
    out_ready = 1'b0;
    drive(4'h8, 4'h9, 1'b0, 4'd8); step();
    drive(4'hF, 4'h2, 1'b0, 4'd9); step();
    in_valid = 1'b0;
    check("full.in_ready", 32'(in_ready), 32'd0);
    expect_head("full.head", 4'h1, 1'b1, 1'b0, 4'd8);
    check("full.cnt", 32'(ovf_cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.ovf_cnt",   32'(ovf_cnt),   32'd0);
    check("mid.in_ready",  32'(in_ready),  32'd0);
    check("mid.out_tag",   32'(out_tag),   32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid.rel.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid.no_stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_stream.md
# add_sub_stream

Streaming wrapper stage around the combinational `add_sub` datapath. It accepts operand commands over a valid/ready handshake and drives `add_sub` with them. It captures `SUM`/`OVERFLOW` into a 2-entry output FIFO and presents results downstream over a second valid/ready handshake, with a saturating overflow/borrow event counter. It sits between the operand source and the result consumer, giving the combinational adder registered, back-pressurable boundaries.

## Interface
- W, 4, operand/result width (`add_sub` is built for 4; no other value is supported)
- TAG_W, 4, width of the opaque tag carried with each command
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  command valid
- in_ready  output  1  stage can accept a command this cycle
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  1 = A−B, 0 = A+B
- in_tag  input  TAG_W  tag returned with the result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  W  result, modulo 2^W
- out_ovf  output  1  carry-out (add) or borrow, A<B (sub)
- out_sub  output  1  operation echo
- out_tag  output  TAG_W  tag echo
- ovf_cnt  output  8  saturating count of accepted commands with `OVERFLOW`=1
- cnt_clr  input  1  synchronous clear of ovf_cnt

## Operation
- Accept = `in_valid && in_ready`; deliver = `out_valid && out_ready`.
- Accepted operands drive one `add_sub` instance in the same cycle:
  - `A`=in_a, `B`=in_b, `SUBTRACT`=in_sub.
  - {in_tag, SUM, OVERFLOW, in_sub} is pushed into the FIFO.
- Arithmetic rules, enforced by `add_sub`:
  - Add: SUM = (A+B) mod 16; OVERFLOW = bit 4 of the 5-bit sum.
  - Sub: SUM = (A−B) mod 16; OVERFLOW = (A<B), unsigned.
- FIFO: 2 entries, in-order, registered count 0..2.
  - in_ready = (count<2) && !rst. It depends only on registered state; there is no out_ready→in_ready path.
  - out_valid = (count>0). Out fields always show the head entry.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, with the head advancing and the new entry appended
  - when count=2, no push occurs (in_ready=0), even if out_ready=1 that cycle
- ovf_cnt:
  - +1 on each accept whose OVERFLOW=1, saturating at 255.
  - cnt_clr forces 0 next cycle and has priority over a simultaneous increment.
- The stage never drops or duplicates commands. Once out_valid is asserted, out fields stay stable until delivered.

## Timing
- Reset (async assert; release synchronous to clk):
  - count=0, out_valid=0, out_sum/out_ovf/out_sub/out_tag=0, ovf_cnt=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
- Latency: a command accepted in cycle N with an empty FIFO gives out_valid=1 in cycle N+1. It is delivered in N+1 if out_ready=1.
- Throughput: 1 command/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two commands are accepted, then in_ready drops in the cycle after the second accept.
- Reset mid-operation discards all FIFO contents and the counter; nothing is delivered after reset.
- X on in_* while in_valid=0 must not propagate to outputs or to ovf_cnt.

## Structure
- Package `add_sub_pkg`:
  - localparams W=4, TAG_W=4, FIFO_DEPTH=2, CNT_W=8.
  - typedef struct packed `add_sub_res_t` {tag, sum, ovf, sub} for FIFO entries.
- One sub-module: the existing `add_sub`, instantiated unchanged. The FIFO and counter are inline.
- Bind the existing `add_sub` assertion module to the instance, using the same clk.

## Test plan
- Add, no carry:
  - stimulus: A=3, B=4, sub=0, tag=1, out_ready=1
  - response: next cycle out_valid=1, sum=7, ovf=0, tag=1; ovf_cnt=0
- Add, carry:
  - stimulus: A=F, B=1, sub=0
  - response: sum=0, ovf=1; ovf_cnt 0→1
- Subtract:
  - stimulus: A=0, B=1, sub=1
  - response: sum=F, ovf=1
  - stimulus: A=F, B=F, sub=1
  - response: sum=0, ovf=0
- Backpressure:
  - stimulus: out_ready=0, stream tags 1,2,3
  - response: tags 1 and 2 accepted, then in_ready=0
  - stimulus: raise out_ready
  - response: delivers 1 then 2; tag 3 is accepted once a slot frees; no loss or reorder
- Counter:
  - stimulus: 260 overflowing adds
  - response: ovf_cnt saturates at 255
  - stimulus: cnt_clr together with an overflowing accept
  - response: ovf_cnt=0
- Reset mid-stream:
  - stimulus: assert rst with count=2
  - response: out_valid=0 and ovf_cnt=0 immediately; in_ready=1 one cycle after release; no stale result appears
